// File: rtl/dds_ctl_pkg.sv
// Shared definitions for the DDS control sequencer: widths, control-word
// bit positions, opcode and state encodings, and the timer load helper.
package dds_ctl_pkg;

    localparam int unsigned CDDS_W = 13;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned ARG_W  = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PROF_W = 3;
    localparam int unsigned PF_W   = 2;

    // Bit positions inside the cdds control word
    localparam int unsigned B_TX_EN   = 12;
    localparam int unsigned B_P_ENA   = 11;
    localparam int unsigned B_TUN_UPD = 10;
    localparam int unsigned B_R_RST   = 9;
    localparam int unsigned B_W_RST   = 8;
    localparam int unsigned B_IO_RST  = 7;
    localparam int unsigned B_M_RST   = 6;
    localparam int unsigned B_IO_UPD  = 5;
    localparam int unsigned B_PROF    = 2;
    localparam int unsigned B_PF      = 0;

    typedef enum logic [OP_W-1:0] {
        OP_WAIT     = 3'd0,
        OP_SET_PROF = 3'd1,
        OP_SET_PF   = 3'd2,
        OP_IO_UPD   = 3'd3,
        OP_MRST     = 3'd4,
        OP_IORST    = 3'd5,
        OP_PBK      = 3'd6,
        OP_TXEN     = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Down-counter preload for a duration of n cycles; 0 behaves like 1
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned n);
        return (n == 0) ? '0 : CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/dds_ctl_seq_if.sv
// Command channel of the DDS control sequencer.
//   cmd_vld : command valid (master -> slave)
//   cmd_op  : 3-bit opcode  (master -> slave)
//   cmd_arg : 16-bit argument (master -> slave)
//   cmd_rdy : sequencer ready to accept (slave -> master)
interface dds_ctl_seq_if;

    logic                             cmd_vld;
    logic                             cmd_rdy;
    logic [dds_ctl_pkg::OP_W-1:0]     cmd_op;
    logic [dds_ctl_pkg::ARG_W-1:0]    cmd_arg;

    modport master (
        output cmd_vld,
        output cmd_op,
        output cmd_arg,
        input  cmd_rdy
    );

    modport slave (
        input  cmd_vld,
        input  cmd_op,
        input  cmd_arg,
        output cmd_rdy
    );

endinterface

// File: rtl/dds_ctl_tmr.sv
// 16-bit duration down-counter. Load with count-1; done_c is high when the
// counter sits at zero, i.e. during the last cycle of the programmed duration.
//   clk, rst_n : clock, async active-low reset
//   load, val  : preload the counter with val
//   run        : decrement by one (saturates at zero)
//   done_c     : counter is zero (combinational)
module dds_ctl_tmr
    import dds_ctl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] val,
    input  logic             run,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q;

    // Load has priority over counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= val;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/dds_ctl_seq.sv
// DDS control sequencer: accepts opcodes on a valid/ready channel and drives
// the 13-bit DDS control word with level fields, one-cycle strobes and
// timed pulses (io_upd, m_rst, io_rst), plus an accepted-command counter.
//   clk, rst_n : clock, async active-low reset
//   bus        : command channel (slave side)
//   cdds       : {tx_en, p_ena, tun_upd, r_rst, w_rst, io_rst, m_rst, io_upd, prof[2:0], pf[1:0]}
//   busy       : a timed command is executing
//   n_cmd      : accepted-command count (wraps)
module dds_ctl_seq
    import dds_ctl_pkg::*;
#(
    parameter int unsigned UPD_W    = 4,
    parameter int unsigned IORST_W  = 4,
    parameter int unsigned MRST_W   = 64,
    parameter int unsigned MRST_REC = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    dds_ctl_seq_if.slave      bus,
    output logic [CDDS_W-1:0] cdds,
    output logic              busy,
    output logic [CNT_W-1:0]  n_cmd
);

    state_e              state_q, state_d;
    logic [CDDS_W-1:0]   cdds_q, cdds_d;
    logic                pend_q, pend_d;
    logic                rdy_q, rdy_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    n_cmd_q, n_cmd_d;

    logic                accept;
    logic                tmr_load;
    logic [CNT_W-1:0]    tmr_val;
    logic                tmr_run;
    logic                tmr_done_c;

    assign accept = bus.cmd_vld & rdy_q;

    dds_ctl_tmr u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .val    (tmr_val),
        .run    (tmr_run),
        .done_c (tmr_done_c)
    );

    // State and output registers; reset drops any pulse immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cdds_q  <= '0;
            pend_q  <= 1'b0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            n_cmd_q <= '0;
        end else begin
            state_q <= state_d;
            cdds_q  <= cdds_d;
            pend_q  <= pend_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            n_cmd_q <= n_cmd_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cdds_d   = cdds_q;
        cdds_d[B_TUN_UPD] = 1'b0;
        cdds_d[B_R_RST]   = 1'b0;
        cdds_d[B_W_RST]   = 1'b0;
        pend_d   = pend_q;
        n_cmd_d  = n_cmd_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_run  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    n_cmd_d = n_cmd_q + CNT_W'(1);
                    case (op_e'(bus.cmd_op))
                        OP_WAIT: begin
                            state_d  = ST_HOLD;
                            tmr_load = 1'b1;
                            tmr_val  = cnt_load(32'(bus.cmd_arg));
                        end
                        OP_SET_PROF: begin
                            cdds_d[B_PROF +: PROF_W] = bus.cmd_arg[2:0];
                            // io_upd follows one cycle after the new profile lands
                            if (bus.cmd_arg[3]) begin
                                state_d  = ST_PULSE;
                                pend_d   = 1'b1;
                                tmr_load = 1'b1;
                                tmr_val  = cnt_load(UPD_W);
                            end
                        end
                        OP_SET_PF: begin
                            cdds_d[B_PF +: PF_W] = bus.cmd_arg[1:0];
                        end
                        OP_IO_UPD: begin
                            cdds_d[B_IO_UPD] = 1'b1;
                            state_d  = ST_PULSE;
                            tmr_load = 1'b1;
                            tmr_val  = cnt_load(UPD_W);
                        end
                        OP_MRST: begin
                            cdds_d[B_M_RST]          = 1'b1;
                            cdds_d[B_PROF +: PROF_W] = '0;
                            cdds_d[B_PF +: PF_W]     = '0;
                            cdds_d[B_TX_EN]          = 1'b0;
                            cdds_d[B_P_ENA]          = 1'b0;
                            state_d  = ST_PULSE;
                            tmr_load = 1'b1;
                            tmr_val  = cnt_load(MRST_W);
                        end
                        OP_IORST: begin
                            cdds_d[B_IO_RST] = 1'b1;
                            state_d  = ST_PULSE;
                            tmr_load = 1'b1;
                            tmr_val  = cnt_load(IORST_W);
                        end
                        OP_PBK: begin
                            cdds_d[B_P_ENA]   = bus.cmd_arg[3];
                            cdds_d[B_TUN_UPD] = bus.cmd_arg[2];
                            cdds_d[B_R_RST]   = bus.cmd_arg[1];
                            cdds_d[B_W_RST]   = bus.cmd_arg[0];
                        end
                        OP_TXEN: begin
                            cdds_d[B_TX_EN] = bus.cmd_arg[0];
                        end
                    endcase
                end
            end

            ST_PULSE: begin
                if (pend_q) begin
                    pend_d           = 1'b0;
                    cdds_d[B_IO_UPD] = 1'b1;
                end else if (tmr_done_c) begin
                    cdds_d[B_IO_UPD] = 1'b0;
                    cdds_d[B_M_RST]  = 1'b0;
                    cdds_d[B_IO_RST] = 1'b0;
                    // Master reset is followed by a recovery hold
                    if (cdds_q[B_M_RST] && (MRST_REC != 0)) begin
                        state_d  = ST_HOLD;
                        tmr_load = 1'b1;
                        tmr_val  = cnt_load(MRST_REC);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    tmr_run = 1'b1;
                end
            end

            ST_HOLD: begin
                if (tmr_done_c) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_run = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rdy_d  = (state_d == ST_IDLE);
        busy_d = (state_d != ST_IDLE);
    end

    assign bus.cmd_rdy = rdy_q;
    assign cdds        = cdds_q;
    assign busy        = busy_q;
    assign n_cmd       = n_cmd_q;

endmodule

// File: tb/tb_dds_ctl_seq.sv
// Self-checking bench for dds_ctl_seq: directed vector table, hand-written
// multi-cycle sequences and random traffic, all compared every cycle against
// a queue-based trace model of the command semantics.
module tb_dds_ctl_seq;
    import dds_ctl_pkg::*;

    localparam int unsigned UPD_W    = 4;
    localparam int unsigned IORST_W  = 4;
    localparam int unsigned MRST_W   = 64;
    localparam int unsigned MRST_REC = 256;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [CDDS_W-1:0] cdds;
    logic              busy;
    logic [15:0]       n_cmd;

    dds_ctl_seq_if bus();

    dds_ctl_seq #(
        .UPD_W    (UPD_W),
        .IORST_W  (IORST_W),
        .MRST_W   (MRST_W),
        .MRST_REC (MRST_REC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .cdds  (cdds),
        .busy  (busy),
        .n_cmd (n_cmd)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each accepted timed command expands into a list of busy cycles, each
    // entry carrying {io_rst, m_rst, io_upd} for that cycle.
    logic [2:0]  mq[$];
    logic        m_rdy  = 1'b0;
    logic        m_busy = 1'b0;
    logic [2:0]  m_pls  = 3'b0;
    logic [2:0]  m_stb  = 3'b0;
    logic [2:0]  m_prof = 3'b0;
    logic [1:0]  m_pf   = 2'b0;
    logic        m_tx   = 1'b0;
    logic        m_pena = 1'b0;
    logic [15:0] m_n    = 16'd0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_rdy = 0; m_busy = 0; m_pls = 0; m_stb = 0;
            m_prof = 0; m_pf = 0; m_tx = 0; m_pena = 0; m_n = 0;
        end else begin
            m_stb = 3'b0;
            if (bus.cmd_vld === 1'b1 && m_rdy) begin
                m_n = m_n + 16'd1;
                case (bus.cmd_op)
                    3'd0: repeat ((bus.cmd_arg == 0) ? 1 : int'(bus.cmd_arg)) mq.push_back(3'b000);
                    3'd1: begin
                        m_prof = bus.cmd_arg[2:0];
                        if (bus.cmd_arg[3]) begin
                            mq.push_back(3'b000);
                            repeat (UPD_W) mq.push_back(3'b001);
                        end
                    end
                    3'd2: m_pf = bus.cmd_arg[1:0];
                    3'd3: repeat (UPD_W) mq.push_back(3'b001);
                    3'd4: begin
                        m_prof = 0; m_pf = 0; m_tx = 0; m_pena = 0;
                        repeat (MRST_W) mq.push_back(3'b010);
                        repeat (MRST_REC) mq.push_back(3'b000);
                    end
                    3'd5: repeat (IORST_W) mq.push_back(3'b100);
                    3'd6: begin
                        m_pena = bus.cmd_arg[3];
                        m_stb  = bus.cmd_arg[2:0];
                    end
                    default: m_tx = bus.cmd_arg[0];
                endcase
            end
            if (mq.size() > 0) begin
                m_pls = mq.pop_front(); m_busy = 1'b1; m_rdy = 1'b0;
            end else begin
                m_pls = 3'b0; m_busy = 1'b0; m_rdy = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        check("cycle {cdds,rdy,busy,n_cmd}",
              64'({cdds, bus.cmd_rdy, busy, n_cmd}),
              64'({m_tx, m_pena, m_stb, m_pls, m_prof, m_pf, m_rdy, m_busy, m_n}));
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    task automatic put(input logic [2:0] op, input logic [15:0] arg);
        bus.cmd_vld = 1'b1;
        bus.cmd_op  = op;
        bus.cmd_arg = arg;
    endtask

    task automatic idle_bus();
        bus.cmd_vld = 1'b0;
        bus.cmd_op  = 3'($urandom);
        bus.cmd_arg = 16'($urandom);
    endtask

    task automatic wait_rdy();
        for (int i = 0; i < 2000 && bus.cmd_rdy !== 1'b1; i++) @(negedge clk);
        check("wait_rdy", 64'(bus.cmd_rdy), 64'd1);
    endtask

    // Issue one command; returns at the first sample after the accept edge
    task automatic run_cmd(input logic [2:0] op, input logic [15:0] arg);
        wait_rdy();
        put(op, arg);
        @(negedge clk);
        idle_bus();
    endtask

    task automatic count_low(output int n);
        n = 0;
        while (bus.cmd_rdy !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] arg;
        logic [12:0] exp_cdds;
        int          exp_len;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n, nm, nb;
        tbl[0]  = '{3'd2, 16'h0002, 13'h0002, 0};
        tbl[1]  = '{3'd7, 16'h0001, 13'h1002, 0};
        tbl[2]  = '{3'd1, 16'h0003, 13'h100E, 0};
        tbl[3]  = '{3'd6, 16'h000F, 13'h1F0E, 0};
        tbl[4]  = '{3'd6, 16'h0000, 13'h100E, 0};
        tbl[5]  = '{3'd3, 16'h0000, 13'h102E, 4};
        tbl[6]  = '{3'd5, 16'h0000, 13'h108E, 4};
        tbl[7]  = '{3'd0, 16'h0000, 13'h100E, 1};
        tbl[8]  = '{3'd0, 16'h0005, 13'h100E, 5};
        tbl[9]  = '{3'd1, 16'h000D, 13'h1016, 5};
        tbl[10] = '{3'd4, 16'h0000, 13'h0040, 320};
        tbl[11] = '{3'd2, 16'h0001, 13'h0001, 0};

        idle_bus();
        repeat (3) @(negedge clk);
        check("reset cdds",  64'(cdds), 64'd0);
        check("reset rdy",   64'(bus.cmd_rdy), 64'd0);
        check("reset busy",  64'(busy), 64'd0);
        check("reset n_cmd", 64'(n_cmd), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rdy after release", 64'(bus.cmd_rdy), 64'd1);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            run_cmd(tbl[i].op, tbl[i].arg);
            check("tbl cdds",  64'(cdds), 64'(tbl[i].exp_cdds));
            check("tbl n_cmd", 64'(n_cmd), 64'(i + 1));
            count_low(n);
            check("tbl busy len", 64'(n), 64'(tbl[i].exp_len));
            @(negedge clk);
            check("tbl strobes off", 64'(cdds[B_TUN_UPD:B_W_RST]), 64'd0);
        end

        // SET_PROF with update; a SET_PF while busy is dropped
        run_cmd(3'd1, 16'h000D);
        check("setprof prof", 64'(cdds[B_PROF +: 3]), 64'd5);
        check("setprof no upd yet", 64'(cdds[B_IO_UPD]), 64'd0);
        put(3'd2, 16'h0003);
        @(negedge clk);
        idle_bus();
        for (int j = 0; j < 4; j++) begin
            check("setprof io_upd", 64'(cdds[B_IO_UPD]), 64'd1);
            @(negedge clk);
        end
        check("setprof io_upd end", 64'(cdds[B_IO_UPD]), 64'd0);
        check("setprof rdy back", 64'(bus.cmd_rdy), 64'd1);
        check("setprof pf kept", 64'(cdds[B_PF +: 2]), 64'd1);

        // MRST after TXEN=1, prof=3
        run_cmd(3'd7, 16'h0001);
        run_cmd(3'd1, 16'h0003);
        check("pre-mrst tx/prof", 64'({cdds[B_TX_EN], cdds[B_PROF +: 3]}), 64'h0B);
        run_cmd(3'd4, 16'h0000);
        check("mrst tx/prof cleared", 64'({cdds[B_TX_EN], cdds[B_PROF +: 3]}), 64'h00);
        nm = 0; n = 0;
        while (bus.cmd_rdy !== 1'b1 && n < 1000) begin
            if (cdds[B_M_RST] === 1'b1) nm++;
            n++;
            @(negedge clk);
        end
        check("mrst m_rst width", 64'(nm), 64'd64);
        check("mrst rdy low len", 64'(n), 64'd320);

        // Long WAIT
        run_cmd(3'd0, 16'd1000);
        nb = 0;
        while (busy === 1'b1 && nb < 3000) begin
            nb++;
            @(negedge clk);
        end
        check("wait1000 busy len", 64'(nb), 64'd1000);

        // Random traffic with one asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            logic [2:0]  op;
            logic [15:0] arg;
            if (c == 1500) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
            op  = 3'($urandom_range(0, 7));
            if (op == 3'd4 && $urandom_range(0, 9) != 0) op = 3'd3;
            arg = 16'($urandom);
            if (op == 3'd0) arg = 16'($urandom_range(0, 12));
            if ($urandom_range(0, 3) != 0) put(op, arg);
            else idle_bus();
            @(negedge clk);
        end
        idle_bus();

        // Reset during cycle 30 of an m_rst pulse
        run_cmd(3'd4, 16'h0000);
        repeat (29) @(negedge clk);
        check("mid-mrst m_rst high", 64'(cdds[B_M_RST]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async rst cdds",  64'(cdds), 64'd0);
        check("async rst n_cmd", 64'(n_cmd), 64'd0);
        check("async rst busy/rdy", 64'({busy, bus.cmd_rdy}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(3'd3, 16'h0000);
        check("post-rst io_upd", 64'(cdds[B_IO_UPD]), 64'd1);
        count_low(n);
        check("post-rst io_upd len", 64'(n), 64'd4);
        check("post-rst n_cmd", 64'(n_cmd), 64'd1);

        // 65536 back-to-back NOP-class commands wrap the counter
        wait_rdy();
        for (int i = 0; i < 65536; i++) begin
            logic [2:0] op;
            case ($urandom_range(0, 2))
                0:       op = 3'd2;
                1:       op = 3'd6;
                default: op = 3'd7;
            endcase
            put(op, 16'($urandom));
            @(negedge clk);
            if (i == 65534) check("n_cmd wrap to 0", 64'(n_cmd), 64'd0);
        end
        idle_bus();
        check("n_cmd after wrap", 64'(n_cmd), 64'd1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dds_ctl_seq.md
DDS_CTL_SEQ -- requirements
Module: dds_ctl_seq

Interface
REQ-001 SHALL have parameter UPD_W, default 4, io_upd pulse width in cycles (1..255).
REQ-002 SHALL have parameter IORST_W, default 4, io_rst pulse width in cycles (1..255).
REQ-003 SHALL have parameter MRST_W, default 64, m_rst pulse width in cycles (1..65535).
REQ-004 SHALL have parameter MRST_REC, default 256, post-m_rst recovery in cycles (0..65535).
REQ-005 SHALL have ports: clk  in  1  system clock, the only clock; rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: cmd_vld  in  1  command valid; cmd_rdy  out  1  ready to accept a command.
REQ-007 SHALL have ports: cmd_op  in  3  opcode; cmd_arg  in  16  argument.
REQ-008 SHALL have ports: cdds  out  13  DDS control word {tx_en[12], p_ena[11], tun_upd[10], r_rst[9], w_rst[8], io_rst[7], m_rst[6], io_upd[5], prof[4:2], pf[1:0]}.
REQ-009 SHALL have ports: busy  out  1  command executing; n_cmd  out  16  accepted-command count.

Function
REQ-010 SHALL accept a command on a rising clk edge where cmd_vld and cmd_rdy are both 1; cmd_rdy SHALL be 1 only in state IDLE.
REQ-011 SHALL drive all outputs from registers, so a change caused by a command accepted at edge k appears after edge k+1.
REQ-012 SHALL implement states IDLE, PULSE, and HOLD; busy SHALL be 1 in PULSE and HOLD.
REQ-013 SHALL implement op 0, WAIT: go to HOLD for cmd_arg cycles; arg 0 SHALL return to IDLE after one cycle, with cmd_rdy low for exactly one cycle.
REQ-014 SHALL implement op 1, SET_PROF: prof <= arg[2:0]. If arg[3]=1, io_upd SHALL go high at k+2 for UPD_W cycles via PULSE. Otherwise the block SHALL stay in IDLE.
REQ-015 SHALL implement op 2, SET_PF: pf <= arg[1:0] and stay in IDLE.
REQ-016 SHALL implement op 3, IO_UPD: io_upd high from k+1 for exactly UPD_W cycles, then IDLE.
REQ-017 SHALL implement op 4, MRST: m_rst high from k+1 for exactly MRST_W cycles, then HOLD for MRST_REC cycles, then IDLE. It SHALL clear prof, pf, tx_en and p_ena to 0 at k+1.
REQ-018 SHALL implement op 5, IORST: io_rst high from k+1 for exactly IORST_W cycles, then IDLE.
REQ-019 SHALL implement op 6, PBK: p_ena <= arg[3] (level); {tun_upd, r_rst, w_rst} <= arg[2:0] for exactly one cycle (k+1), then 0. It SHALL stay in IDLE.
REQ-020 SHALL implement op 7, TXEN: tx_en <= arg[0] and stay in IDLE.
REQ-021 SHALL allow at most one of io_upd, m_rst, io_rst to be high in any cycle.
REQ-022 SHALL keep level fields (prof, pf, tx_en, p_ena) stable except on their own opcode or MRST.
REQ-023 SHALL ignore cmd_op and cmd_arg when cmd_vld=1 and cmd_rdy=0; there is no queueing and no error flag.
REQ-024 SHALL count with a 16-bit duration counter, loaded with the count minus 1 and ending at 0; there SHALL be no off-by-one at count 1.
REQ-025 SHALL increment n_cmd by 1 per accepted command (including WAIT) and wrap from 65535 to 0.
REQ-026 SHALL accept a new command in the cycle cmd_rdy returns to 1, giving back-to-back IO_UPD commands a one-cycle low gap on io_upd.

Reset
REQ-027 SHALL, while rst_n=0, force the state to IDLE, cdds to 0, busy to 0, n_cmd to 0 and cmd_rdy to 0.
REQ-028 SHALL set cmd_rdy to 1 on the first clk edge after rst_n deasserts.
REQ-029 SHALL, when rst_n asserts mid-pulse or mid-HOLD, drop the pulse immediately (asynchronously) without completing it.

Structure
REQ-030 SHALL place the opcode enum, state enum, cdds bit-position constants and CDDS_W=13 in shared package dds_ctl_pkg.
REQ-031 SHALL isolate the down-counter (load, run, done) in sub-module dds_ctl_tmr, instantiated once.
REQ-032 SHALL be 120-400 lines of RTL in total, with no additional clocks or latches.

Verification
REQ-033 SHALL verify: IO_UPD with UPD_W=4 accepted at edge 10 -> io_upd high during cycles 11-14; cmd_rdy 0 during cycles 11-14 and 1 at 15; n_cmd=1.
REQ-034 SHALL verify: SET_PROF arg=0x000D -> prof=5 at k+1 and io_upd high k+2..k+5; a SET_PF presented at k+1 is ignored and pf stays unchanged.
REQ-035 SHALL verify: MRST with MRST_W=64, MRST_REC=256 after TXEN=1 and prof=3 -> tx_en=0 and prof=0 at k+1; m_rst high 64 cycles; cmd_rdy returns at k+321.
REQ-036 SHALL verify: PBK arg=0x000F -> p_ena=1 held, and tun_upd/r_rst/w_rst high only at k+1; PBK arg=0x0000 then clears p_ena.
REQ-037 SHALL verify: WAIT arg=0 -> cmd_rdy low for one cycle; WAIT arg=1000 -> busy high for exactly 1000 cycles.
REQ-038 SHALL verify: rst_n low at cycle 30 of the m_rst pulse -> cdds=0 immediately, n_cmd=0; after release, IO_UPD works normally and 65536 NOP-class commands wrap n_cmd to 0.
